daq_frame_gen: RTL and testbench

- Upstream producer for the 32-bit capture FIFO that feeds the xillybus_read_32 stream.
- Emits fixed-length DAQ frames, each one head word, PAYLOAD_WORDS payload words, then one tail word.
- Started, stopped and reset by a command byte taken from mem_8 location 0.
- Replaces the inline test-data generator. Sits in the bus_clk domain and writes directly into the FIFO's wr_en/din, honouring its full flag.

---
 rtl/daq_frame_gen.sv | 98 +++++++++
 tb/tb_daq_frame_gen.sv | 136 +++++++++++++
 2 files changed

// File: rtl/daq_frame_gen.sv
// daq_frame_gen: paced head/payload/tail frame writer for the capture FIFO, command-byte controlled.
// Optional DAQ_FRAME_SEQ_EN puts the frame sequence number in the low half of the tail word.
module daq_frame_gen #(
  parameter int unsigned PAYLOAD_WORDS = 24,
  parameter logic [31:0] HEAD_WORD     = 32'hAAAAAAAA,
  parameter logic [31:0] TAIL_WORD     = 32'hF0F0F0F0,
  parameter int unsigned PACE_LOG2     = 1,
  parameter logic [7:0]  CMD_START     = 8'hFF,
  parameter logic [7:0]  CMD_RESET     = 8'hC0,
  parameter logic [7:0]  CMD_CLOSE     = 8'hC7
) (
  input  logic        bus_clk,
  input  logic        reset_n,
  input  logic [7:0]  cfg_cmd,
  input  logic        stream_open,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [31:0] fifo_din,
  output logic        running,
  output logic [15:0] frame_count,
  output logic        stalled,
  output logic        led_active
);
  localparam int unsigned PW = PACE_LOG2 > 0 ? PACE_LOG2 : 1;
  typedef enum logic [1:0] {IDLE, HEAD, PAYLOAD, TAIL} state_t;
  state_t state, state_n;
  logic [7:0] k, k_n, cmd_prev;
  logic [PW-1:0] pace;
  logic stop_pending, sp_n, stalled_n, pace_ok, fire_reset, fire_close, fire_start, abort, last;
  logic [15:0] fc_n;
  logic [31:0] tail_word;
  assign pace_ok    = (PACE_LOG2 == 0) || (pace == '0);
  assign fire_reset = cfg_cmd != cmd_prev && cfg_cmd == CMD_RESET;
  assign fire_close = cfg_cmd != cmd_prev && cfg_cmd == CMD_CLOSE;
  assign fire_start = cfg_cmd != cmd_prev && cfg_cmd == CMD_START;
  assign abort      = fire_reset || !stream_open;
  assign running    = state != IDLE;
  assign fifo_wr_en = running && pace_ok && !fifo_full;
  assign last       = k == 8'(PAYLOAD_WORDS - 1);
`ifdef DAQ_FRAME_SEQ_EN
  assign tail_word  = {TAIL_WORD[31:16], frame_count};
`else
  assign tail_word  = TAIL_WORD;
`endif
  // payload halves are 2k+1 and 2k+2
  assign fifo_din = state == HEAD    ? HEAD_WORD :
                    state == PAYLOAD ? {{7'd0, k, 1'b1}, {7'd0, k, 1'b0} + 16'd2} :
                    state == TAIL    ? tail_word : 32'h0;
  always_comb begin
    state_n   = state;
    k_n       = k;
    sp_n      = stop_pending | (fire_close && running);
    fc_n      = fire_reset ? 16'h0 : frame_count + 16'(fifo_wr_en && state == TAIL);
    stalled_n = !abort && (stalled || (running && pace_ok && fifo_full));
    if (fire_start && state == IDLE) state_n = HEAD;
    if (fifo_wr_en)
      case (state)
        HEAD: begin
          state_n = PAYLOAD;
          k_n     = '0;
        end
        PAYLOAD: begin
          state_n = last ? TAIL : PAYLOAD;
          k_n     = k + 8'(!last);
        end
        TAIL: begin
          state_n = sp_n ? IDLE : HEAD;
          sp_n    = 1'b0;
        end
        default: ;
      endcase
    if (abort) begin
      state_n = IDLE;
      k_n     = '0;
      sp_n    = 1'b0;
    end
  end
  always_ff @(posedge bus_clk or negedge reset_n)
    if (!reset_n) begin
      state        <= IDLE;
      k            <= '0;
      pace         <= '0;
      cmd_prev     <= 8'h00;
      stop_pending <= 1'b0;
      frame_count  <= '0;
      stalled      <= 1'b0;
      led_active   <= 1'b0;
    end else begin
      state        <= state_n;
      k            <= k_n;
      pace         <= pace + PW'(PACE_LOG2 != 0);
      cmd_prev     <= cfg_cmd;
      stop_pending <= sp_n;
      frame_count  <= fc_n;
      stalled      <= stalled_n;
      led_active   <= fifo_wr_en;
    end
endmodule

// File: tb/tb_daq_frame_gen.sv
// tb_daq_frame_gen: directed plus random command/full/open stimulus against a frame-position model.
module tb_daq_frame_gen;
  localparam int PW = 24;
  localparam int P  = 1;
  localparam logic [31:0] TW = 32'hF0F0F0F0;
  logic bus_clk = 0, reset_n = 0, stream_open = 1, fifo_full = 0;
  logic [7:0] cfg_cmd = 8'h00;
  logic fifo_wr_en, running, stalled, led_active;
  logic [31:0] fifo_din;
  logic [15:0] frame_count;
  int errs = 0, checks = 0;
  bit m_act = 0, m_stop = 0, m_stall = 0, m_led = 0;
  int m_pos = 0, m_cyc = 0;
  logic [15:0] m_cnt = 0;
  logic [7:0] m_prev = 0;
  logic [7:0] codes [5] = '{8'hFF, 8'hC7, 8'hC0, 8'h00, 8'h55};

  always #5 bus_clk = ~bus_clk;

  daq_frame_gen #(.PAYLOAD_WORDS(PW), .PACE_LOG2(P)) dut (
    .bus_clk(bus_clk), .reset_n(reset_n), .cfg_cmd(cfg_cmd), .stream_open(stream_open),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .running(running),
    .frame_count(frame_count), .stalled(stalled), .led_active(led_active));

  function automatic logic [31:0] word(int pos);
    if (!m_act) return 32'h0;
    if (pos == 0) return 32'hAAAAAAAA;
    if (pos == PW + 1)
`ifdef DAQ_FRAME_SEQ_EN
      return {TW[31:16], m_cnt};
`else
      return TW;
`endif
    return {16'(2 * pos - 1), 16'(2 * pos)};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, m_cyc);
    end
  endtask

  task automatic cyc();
    bit ok, wr, ch, rs, cl, st, act;
    @(negedge bus_clk);
    ok = (m_cyc % (1 << P)) == 0;
    wr = m_act && ok && !fifo_full;
    chk("wr_en", 32'(fifo_wr_en), 32'(wr));
    chk("din", fifo_din, word(m_pos));
    chk("running", 32'(running), 32'(m_act));
    chk("frame_count", 32'(frame_count), 32'(m_cnt));
    chk("stalled", 32'(stalled), 32'(m_stall));
    chk("led", 32'(led_active), 32'(m_led));
    ch = cfg_cmd != m_prev;
    rs = ch && cfg_cmd == 8'hC0;
    cl = ch && cfg_cmd == 8'hC7;
    st = ch && cfg_cmd == 8'hFF;
    act = m_act;
    if (cl && act) m_stop = 1;
    if (act && ok && fifo_full) m_stall = 1;
    if (wr) begin
      if (m_pos == PW + 1) begin
        m_cnt++;
        m_pos = 0;
        if (m_stop) begin
          m_act = 0;
          m_stop = 0;
        end
      end else m_pos++;
    end
    if (st && !act) begin
      m_act = 1;
      m_pos = 0;
    end
    if (rs || !stream_open) begin
      m_act = 0;
      m_pos = 0;
      m_stop = 0;
      m_stall = 0;
      if (rs) m_cnt = 0;
    end
    m_led = wr;
    m_prev = cfg_cmd;
    m_cyc++;
    @(posedge bus_clk);
    #1;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    @(posedge bus_clk);
    #1;
    chk("rst_wr_en", 32'(fifo_wr_en), 32'h0);
    chk("rst_running", 32'(running), 32'h0);
    chk("rst_count", 32'(frame_count), 32'h0);
    chk("rst_stalled", 32'(stalled), 32'h0);
    chk("rst_led", 32'(led_active), 32'h0);
    chk("rst_din", fifo_din, 32'h0);
    reset_n = 1;
    run(3);
    cfg_cmd = 8'hFF;
    run(120);
    cfg_cmd = 8'hC7;
    run(100);
    cfg_cmd = 8'hFF;
    run(18);
    fifo_full = 1;
    run(10);
    fifo_full = 0;
    run(60);
    cfg_cmd = 8'hC0;
    run(4);
    cfg_cmd = 8'hFF;
    run(40);
    stream_open = 0;
    run(3);
    stream_open = 1;
    cfg_cmd = 8'h00;
    run(2);
    cfg_cmd = 8'hFF;
    run(60);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(15) == 0) cfg_cmd = codes[$urandom_range(4)];
      fifo_full = $urandom_range(3) == 0;
      stream_open = $urandom_range(199) != 0;
      cyc();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
